// File: rtl/kronecker_sched_if.sv
// Handshake bundle for the Kronecker-delta sequencer: control, byte and PRNG streams, kronecker link, results.
// With KRON_SCHED_STALL_CNT_EN defined the bundle also carries the 16-bit stall_cnt.
interface kronecker_sched_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             rnd_valid;
  logic [2:0]       rnd_data;
  logic             rnd_ready;
  logic [15:0]      kr_inp;
  logic [2:0]       kr_rand;
  logic [1:0]       kr_z;
  logic             out_valid;
  logic [1:0]       out_z;
  logic [IDX_W-1:0] out_idx;
`ifdef KRON_SCHED_STALL_CNT_EN
  logic [15:0]      stall_cnt;

  modport master (
    output start, in_valid, in_data, rnd_valid, rnd_data, kr_z,
    input  busy, done, in_ready, rnd_ready, kr_inp, kr_rand,
    input  out_valid, out_z, out_idx, stall_cnt
  );
  modport slave (
    input  start, in_valid, in_data, rnd_valid, rnd_data, kr_z,
    output busy, done, in_ready, rnd_ready, kr_inp, kr_rand,
    output out_valid, out_z, out_idx, stall_cnt
  );
`else
  modport master (
    output start, in_valid, in_data, rnd_valid, rnd_data, kr_z,
    input  busy, done, in_ready, rnd_ready, kr_inp, kr_rand,
    input  out_valid, out_z, out_idx
  );
  modport slave (
    input  start, in_valid, in_data, rnd_valid, rnd_data, kr_z,
    output busy, done, in_ready, rnd_ready, kr_inp, kr_rand,
    output out_valid, out_z, out_idx
  );
`endif
endinterface

// File: rtl/kronecker_sched.sv
// Batch sequencer feeding shared bytes plus fresh randomness into a 3-level DOM-AND Kronecker unit.
// Optional randomness-starvation counter enabled by KRON_SCHED_STALL_CNT_EN.
module kronecker_sched #(
  parameter int NUM_BYTES = 16,
  parameter int LAT       = 3,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  kronecker_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic             w_issue;
  logic             w_start_ok;
  logic             w_pipe_empty;
  logic [LAT:0]     r_vld_p;
  logic [IDX_W-1:0] r_idx_p [LAT+1];
  logic [15:0]      r_kr_inp;
  logic [2:0]       r_kr_rand;

  // Only the tail stage may still hold a result when DRAIN hands over to DONE.
  assign w_pipe_empty = ~|r_vld_p[LAT-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = bus.in_valid && bus.rnd_valid && !rst;
        if (w_issue && (r_cnt == LAST_IDX)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pipe_empty) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vld_p <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) r_cnt <= '0;
      else if (w_issue && (r_cnt != LAST_IDX)) r_cnt <= r_cnt + 1'b1;
      r_vld_p <= {r_vld_p[LAT-1:0], w_issue};
    end
  end

  // p0: kr_inp/kr_rand register; p1..pLAT: kronecker stages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kr_inp  <= '0;
      r_kr_rand <= '0;
      for (int i = 0; i <= LAT; i++) r_idx_p[i] <= '0;
    end else begin
      if (w_issue) begin
        r_kr_inp  <= bus.in_data;
        r_kr_rand <= bus.rnd_data;
      end
      r_idx_p[0] <= r_cnt;
      for (int i = 1; i <= LAT; i++) r_idx_p[i] <= r_idx_p[i-1];
    end
  end

  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.in_ready  = w_issue;
  assign bus.rnd_ready = w_issue;
  assign bus.kr_inp    = r_kr_inp;
  assign bus.kr_rand   = r_kr_rand;
  assign bus.out_valid = r_vld_p[LAT];
  assign bus.out_z     = r_vld_p[LAT] ? bus.kr_z : 2'b00;
  assign bus.out_idx   = r_vld_p[LAT] ? r_idx_p[LAT] : '0;

`ifdef KRON_SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) r_stall_cnt <= '0;
    else if ((r_state == S_RUN) && bus.in_valid && !bus.rnd_valid)
      r_stall_cnt <= sat_inc16(r_stall_cnt);
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_kronecker_sched.sv
// Directed bench for kronecker_sched: a 16-byte and a 1-byte instance, each behind a Kronecker stand-in,
// checked every cycle against a batch/timestamp scoreboard plus hand-computed milestones.
module tb_kronecker_sched;
  localparam int LAT   = 3;
  localparam int IDX_W = 4;
  localparam int QD    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kronecker_sched_if #(.IDX_W(IDX_W)) bus0 ();
  kronecker_sched_if #(.IDX_W(IDX_W)) bus1 ();

  kronecker_sched #(.NUM_BYTES(16), .LAT(LAT), .IDX_W(IDX_W)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  kronecker_sched #(.NUM_BYTES(1), .LAT(LAT), .IDX_W(IDX_W)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Kronecker stand-in: z0 = mask, z1 = delta ^ mask, LAT cycles after kr_inp
  function automatic logic [1:0] kron_f(input logic [15:0] inp, input logic [2:0] r);
    logic d;
    logic m;
    d = (inp[7:0] == inp[15:8]);
    m = r[0] ^ r[2];
    return {d ^ m, m};
  endfunction

  logic [1:0] kz0 [LAT];
  logic [1:0] kz1 [LAT];
  always @(posedge clk) begin
    kz0[0] <= kron_f(bus0.kr_inp, bus0.kr_rand);
    kz1[0] <= kron_f(bus1.kr_inp, bus1.kr_rand);
    for (int i = 1; i < LAT; i++) begin
      kz0[i] <= kz0[i-1];
      kz1[i] <= kz1[i-1];
    end
  end
  assign bus0.kr_z = kz0[LAT-1];
  assign bus1.kr_z = kz1[LAT-1];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
  endtask

  // Scoreboard state
  int          NB [2] = '{16, 1};
  bit          m_busy [2];
  int          m_iss [2];
  int          m_done_at [2] = '{-1, -1};
  logic [15:0] m_ki [2];
  logic [2:0]  m_kr [2];
  int          m_stall [2];
  int          q_due [2][QD];
  int          q_idx [2][QD];
  bit          q_dz [2][QD];
  int          q_hd [2];
  int          q_tl [2];
  int          hs [2];
  int          res_cnt [2];
  int          done_cnt [2];
  int          done_log [2];
  int          out_log [2][256];

  function automatic logic [15:0] pat(input int i);
    return (i % 2 == 0) ? 16'h5A5A : 16'h5B5A;
  endfunction

  task automatic model_step(input int k, input bit r_in, input bit st, input bit iv,
                            input logic [15:0] id, input bit rv, input logic [2:0] rd,
                            input bit ir, input bit rr, input bit bsy, input bit dn,
                            input bit ov, input logic [1:0] oz, input logic [IDX_W-1:0] oi,
                            input logic [15:0] ki, input logic [2:0] kra, input logic [15:0] sc);
    bit e_iss;
    bit e_ov;
    int slot;
    e_iss = m_busy[k] && (m_iss[k] < NB[k]) && iv && rv && !r_in;
    chk("in_ready", k, ir, e_iss);
    chk("rnd_ready", k, rr, e_iss);
    chk("busy", k, bsy, m_busy[k]);
    chk("done", k, dn, cyc == m_done_at[k]);
    chk("kr_inp", k, ki, m_ki[k]);
    chk("kr_rand", k, kra, m_kr[k]);
`ifdef KRON_SCHED_STALL_CNT_EN
    chk("stall_cnt", k, sc, m_stall[k]);
`else
    if (sc != 16'h0) $display("note: unexpected stall value");
`endif
    slot = q_hd[k] % QD;
    e_ov = (q_hd[k] != q_tl[k]) && (q_due[k][slot] == cyc);
    chk("out_valid", k, ov, e_ov);
    if (e_ov) begin
      chk("out_idx", k, oi, q_idx[k][slot]);
      chk("delta", k, oz[0] ^ oz[1], q_dz[k][slot]);
      q_hd[k]++;
    end else begin
      chk("out_z_idle", k, oz, 0);
      chk("out_idx_idle", k, oi, 0);
    end
    if (ov) begin
      out_log[k][res_cnt[k] % 256] = cyc;
      res_cnt[k]++;
    end
    if (dn) begin
      done_cnt[k]++;
      done_log[k] = cyc;
    end
    if (ir) hs[k]++;
    if (r_in) begin
      m_busy[k]    = 1'b0;
      m_iss[k]     = 0;
      m_done_at[k] = -1;
      m_ki[k]      = '0;
      m_kr[k]      = '0;
      m_stall[k]   = 0;
      q_hd[k]      = q_tl[k];
    end else begin
      if (m_busy[k] && (m_iss[k] < NB[k]) && iv && !rv && (m_stall[k] != 16'hFFFF))
        m_stall[k]++;
      if (e_iss) begin
        slot = q_tl[k] % QD;
        q_due[k][slot] = cyc + 1 + LAT;
        q_idx[k][slot] = m_iss[k];
        q_dz[k][slot]  = (id[7:0] == id[15:8]);
        q_tl[k]++;
        m_ki[k] = id;
        m_kr[k] = rd;
        m_iss[k]++;
        if (m_iss[k] == NB[k]) m_done_at[k] = cyc + LAT + 2;
      end
      if (!m_busy[k] && st && (cyc != m_done_at[k])) begin
        m_busy[k]  = 1'b1;
        m_iss[k]   = 0;
        m_stall[k] = 0;
      end
      if (cyc + 1 == m_done_at[k]) m_busy[k] = 1'b0;
    end
  endtask

  function automatic logic [15:0] stall_of(input int k);
`ifdef KRON_SCHED_STALL_CNT_EN
    return (k == 0) ? bus0.stall_cnt : bus1.stall_cnt;
`else
    return (k == 0) ? 16'h0 : 16'h0;
`endif
  endfunction

  task automatic tick(input bit r, input bit s0, input bit v0, input bit rv0,
                      input bit s1, input bit v1, input bit rv1);
    @(posedge clk);
    #1;
    rst            = r;
    bus0.start     = s0;
    bus0.in_valid  = v0;
    bus0.rnd_valid = rv0;
    bus0.in_data   = pat(hs[0]);
    bus0.rnd_data  = 3'($urandom_range(0, 7));
    bus1.start     = s1;
    bus1.in_valid  = v1;
    bus1.rnd_valid = rv1;
    bus1.in_data   = pat(hs[1] + 1);
    bus1.rnd_data  = 3'($urandom_range(0, 7));
    @(negedge clk);
    if (chk_en) begin
      model_step(0, rst, bus0.start, bus0.in_valid, bus0.in_data, bus0.rnd_valid, bus0.rnd_data,
                 bus0.in_ready, bus0.rnd_ready, bus0.busy, bus0.done, bus0.out_valid,
                 bus0.out_z, bus0.out_idx, bus0.kr_inp, bus0.kr_rand, stall_of(0));
      model_step(1, rst, bus1.start, bus1.in_valid, bus1.in_data, bus1.rnd_valid, bus1.rnd_data,
                 bus1.in_ready, bus1.rnd_ready, bus1.busy, bus1.done, bus1.out_valid,
                 bus1.out_z, bus1.out_idx, bus1.kr_inp, bus1.kr_rand, stall_of(1));
    end
  endtask

  int t0;
  int snap_r;
  int snap_d;

  initial begin
    bus0.start = 0; bus0.in_valid = 0; bus0.rnd_valid = 0; bus0.in_data = '0; bus0.rnd_data = '0;
    bus1.start = 0; bus1.in_valid = 0; bus1.rnd_valid = 0; bus1.in_data = '0; bus1.rnd_data = '0;

    tick(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    tick(1, 0, 1, 1, 0, 1, 1);
    tick(0, 0, 1, 1, 0, 1, 1);
    chk("rst_busy", 0, bus0.busy, 0);
    chk("rst_done", 0, bus0.done, 0);
    chk("rst_in_ready", 0, bus0.in_ready, 0);
    chk("rst_out_valid", 0, bus0.out_valid, 0);
    chk("rst_kr_inp", 0, bus0.kr_inp, 0);
    chk("rst_in_ready", 1, bus1.in_ready, 0);
    tick(0, 0, 0, 0, 0, 0, 0);

    // Back-to-back batch with alternating delta pattern
    snap_r = res_cnt[0]; snap_d = done_cnt[0];
    for (int r = 0; r < 26; r++) begin
      tick(0, r == 0, 1, 1, 0, 0, 0);
      if (r == 0) t0 = cyc;
    end
    chk("b2b_first_out", 0, out_log[0][snap_r] - t0, 5);
    chk("b2b_last_out", 0, out_log[0][snap_r + 15] - t0, 20);
    chk("b2b_done_at", 0, done_log[0] - t0, 21);
    chk("b2b_results", 0, res_cnt[0] - snap_r, 16);
    chk("b2b_dones", 0, done_cnt[0] - snap_d, 1);

    // Randomness starvation in relative cycles 3..6
    snap_r = res_cnt[0]; snap_d = done_cnt[0];
    for (int r = 0; r < 30; r++) begin
      tick(0, r == 0, 1, !(r >= 3 && r <= 6), 0, 0, 0);
      if (r == 0) t0 = cyc;
    end
    chk("starve_done_at", 0, done_log[0] - t0, 25);
    chk("starve_results", 0, res_cnt[0] - snap_r, 16);
`ifdef KRON_SCHED_STALL_CNT_EN
    chk("starve_stall_cnt", 0, bus0.stall_cnt, 4);
`endif

    // Start pulses during RUN and DRAIN are ignored
    snap_r = res_cnt[0]; snap_d = done_cnt[0];
    for (int r = 0; r < 28; r++) begin
      tick(0, r == 0 || r == 8 || r == 18, 1, 1, 0, 0, 0);
      if (r == 0) t0 = cyc;
    end
    chk("ign_done_at", 0, done_log[0] - t0, 21);
    chk("ign_results", 0, res_cnt[0] - snap_r, 16);
    chk("ign_dones", 0, done_cnt[0] - snap_d, 1);

    // Reset the cycle after index 7 issues
    snap_d = done_cnt[0];
    for (int r = 0; r < 10; r++) begin
      tick(r == 9, r == 0, 1, 1, 0, 0, 0);
      if (r == 0) t0 = cyc;
    end
    tick(0, 0, 1, 1, 0, 0, 0);
    chk("mid_rst_busy", 0, bus0.busy, 0);
    chk("mid_rst_out_valid", 0, bus0.out_valid, 0);
    chk("mid_rst_in_ready", 0, bus0.in_ready, 0);
    chk("mid_rst_out_idx", 0, bus0.out_idx, 0);
    chk("mid_rst_out_z", 0, bus0.out_z, 0);
    chk("mid_rst_kr_inp", 0, bus0.kr_inp, 0);
    chk("mid_rst_kr_rand", 0, bus0.kr_rand, 0);
    for (int r = 0; r < 6; r++) tick(0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_no_done", 0, done_cnt[0] - snap_d, 0);
    snap_r = res_cnt[0];
    for (int r = 0; r < 26; r++) begin
      tick(0, r == 0, 1, 1, 0, 0, 0);
      if (r == 0) t0 = cyc;
    end
    chk("restart_first_out", 0, out_log[0][snap_r] - t0, 5);
    chk("restart_done_at", 0, done_log[0] - t0, 21);
    chk("restart_results", 0, res_cnt[0] - snap_r, 16);

    // Single-byte batch
    snap_r = res_cnt[1]; snap_d = done_cnt[1];
    for (int r = 0; r < 12; r++) begin
      tick(0, 0, 0, 0, r == 0, 1, 1);
      if (r == 0) t0 = cyc;
    end
    chk("edge_out_at", 1, out_log[1][snap_r] - t0, 5);
    chk("edge_done_at", 1, done_log[1] - t0, 6);
    chk("edge_results", 1, res_cnt[1] - snap_r, 1);
    chk("edge_dones", 1, done_cnt[1] - snap_d, 1);

    tick(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
